// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end with PC generator, imem handshake and fetch queue.
// Optional performance counters are enabled with `define FETCH_PERF_EN.
module fetch_unit #(
  parameter int PC_W = 32,
  parameter int INS_W = 32,
  parameter int FQ_DEPTH = 4,
  parameter int MAX_OUTST = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [PC_W-1:0]  imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [INS_W-1:0] imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [PC_W-1:0]  id_pc,
  output logic [INS_W-1:0] id_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetched,
  output logic [31:0]      perf_squashed,
  output logic [31:0]      perf_stall
`endif
);
  localparam int CW = $clog2(FQ_DEPTH + 1) + 1;
  localparam int QW = $clog2(FQ_DEPTH);
  localparam int PW = MAX_OUTST > 1 ? $clog2(MAX_OUTST) : 1;
  localparam logic [INS_W-1:0] NOP = INS_W'(32'h0000_0013);
  logic [PC_W-1:0]  fpc;
  logic [CW-1:0]    outst, outst_nxt, squash, occ;
  logic [PC_W-1:0]  pcf [MAX_OUTST];
  logic [PW-1:0]    pcf_wr, pcf_rd;
  logic [PC_W-1:0]  q_pc [FQ_DEPTH];
  logic [INS_W-1:0] q_ins [FQ_DEPTH];
  logic [QW-1:0]    q_wr, q_rd;
  logic             req_fire, rsp_push, id_fire;
  // Credit rule: in-flight requests plus queued entries never exceed the queue size.
  assign imem_req_valid = !reset && !redirect_valid && outst < CW'(MAX_OUTST)
                          && (outst + occ) < CW'(FQ_DEPTH);
  assign imem_req_addr = fpc & ~PC_W'(3);
  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_push = imem_rsp_valid && squash == '0 && !redirect_valid;
  assign id_valid = occ != '0 && !redirect_valid;
  assign id_fire = id_valid && id_ready;
  assign id_pc = occ == '0 ? '0 : q_pc[q_rd];
  assign id_instr = occ == '0 ? NOP : q_ins[q_rd];
  assign outst_nxt = outst + CW'(req_fire) - CW'(imem_rsp_valid);
  always_ff @(posedge clk) begin
    if (reset) begin
      fpc <= RESET_PC;
      outst <= '0;
      squash <= '0;
      occ <= '0;
      pcf_wr <= '0;
      pcf_rd <= '0;
      q_wr <= '0;
      q_rd <= '0;
    end else begin
      outst <= outst_nxt;
      if (req_fire) pcf_wr <= pcf_wr == PW'(MAX_OUTST - 1) ? '0 : pcf_wr + 1'b1;
      if (imem_rsp_valid) pcf_rd <= pcf_rd == PW'(MAX_OUTST - 1) ? '0 : pcf_rd + 1'b1;
      if (redirect_valid) begin
        fpc <= redirect_pc & ~PC_W'(3);
        squash <= outst_nxt;
        occ <= '0;
        q_wr <= '0;
        q_rd <= '0;
      end else begin
        if (req_fire) fpc <= fpc + PC_W'(4);
        if (imem_rsp_valid && squash != '0) squash <= squash - 1'b1;
        if (rsp_push) q_wr <= q_wr + 1'b1;
        if (id_fire) q_rd <= q_rd + 1'b1;
        occ <= occ + CW'(rsp_push) - CW'(id_fire);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (req_fire) pcf[pcf_wr] <= imem_req_addr;
    if (rsp_push) begin
      q_pc[q_wr] <= pcf[pcf_rd];
      q_ins[q_wr] <= imem_rsp_data;
    end
  end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_squashed <= '0;
      perf_stall <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(rsp_push);
      perf_squashed <= perf_squashed + 32'(imem_rsp_valid && !rsp_push);
      perf_stall <= perf_stall + 32'(id_valid && !id_ready);
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a fixed-latency in-order memory model.
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam int FQ = 4;
  logic        clk = 0, reset = 1;
  logic        imem_req_valid, imem_req_ready = 1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid, id_ready = 1;
  logic [31:0] id_pc, id_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_squashed, perf_stall;
`endif

  fetch_unit #(.PC_W(32), .INS_W(32), .FQ_DEPTH(FQ), .MAX_OUTST(2), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_squashed(perf_squashed), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; int due;} mreq_t;
  typedef struct {logic [31:0] pc; logic [31:0] ins;} exp_t;
  mreq_t memq[$];
  exp_t  sb[$];
  mreq_t mtmp;
  int cyc = 0, lat = 1, tests = 0, fails = 0;

  function automatic logic [31:0] ins_of(logic [31:0] a);
    return a ^ 32'h5A5A_0003;
  endfunction

  // Memory model: records accepted requests, answers each one lat cycles later, in order.
  always @(negedge clk) begin
    if (reset) memq.delete();
    else begin
      if (imem_rsp_valid && memq.size() > 0) memq.delete(0);
      if (imem_req_valid && imem_req_ready) begin
        mtmp.addr = imem_req_addr;
        mtmp.due = cyc + lat;
        memq.push_back(mtmp);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1;
      imem_rsp_data = ins_of(memq[0].addr);
    end else begin
      imem_rsp_valid = 0;
      imem_rsp_data = '0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    redirect_valid = 0;
    imem_req_ready = 1;
    id_ready = 1;
    step();
    step();
    sb.delete();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1;
    step();
    @(negedge clk);
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    tests++; if (id_valid !== 1'b0) begin fails++; $display("FAIL reset_id_valid: got %b expected 0", id_valid); end
    tests++; if (id_pc !== 32'h0) begin fails++; $display("FAIL reset_id_pc: got %h expected 0", id_pc); end
    tests++; if (id_instr !== 32'h13) begin fails++; $display("FAIL reset_id_instr: got %h expected 00000013", id_instr); end
    step();
    reset = 0;
    @(negedge clk);
    tests++; if (imem_req_valid !== 1'b1) begin fails++; $display("FAIL reset_first_req: got %b expected 1", imem_req_valid); end
    tests++; if (imem_req_addr !== 32'h0) begin fails++; $display("FAIL reset_first_addr: got %h expected 0", imem_req_addr); end
  endtask

  task automatic test_basic();
    logic [31:0] exp_addr = 0;
    int first_acc = -1, first_id = -1;
    exp_t e;
    lat = 1;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        tests++; if (imem_req_addr !== exp_addr) begin fails++; $display("FAIL basic_addr: got %h expected %h", imem_req_addr, exp_addr); end
        e.pc = exp_addr; e.ins = ins_of(exp_addr); sb.push_back(e);
        if (first_acc < 0) first_acc = cyc;
        exp_addr += 4;
      end
      if (first_id >= 0) begin
        tests++; if (id_valid !== 1'b1) begin fails++; $display("FAIL basic_tput: got id_valid %b expected 1 at cycle %0d", id_valid, cyc); end
      end
      if (id_valid && id_ready) begin
        if (first_id < 0) begin
          first_id = cyc;
          tests++; if (first_id != first_acc + 2) begin fails++; $display("FAIL basic_latency: got %0d cycles expected 2", first_id - first_acc); end
          tests++; if (id_pc !== 32'h0) begin fails++; $display("FAIL basic_first_pc: got %h expected 0", id_pc); end
        end
        if (sb.size() == 0) begin tests++; fails++; $display("FAIL basic_unexpected: got pc %h expected none", id_pc); end
        else begin
          e = sb.pop_front();
          tests++; if (id_pc !== e.pc || id_instr !== e.ins) begin fails++; $display("FAIL basic_id: got %h/%h expected %h/%h", id_pc, id_instr, e.pc, e.ins); end
        end
      end
      step();
    end
    tests++; if (first_id < 0) begin fails++; $display("FAIL basic_timeout: got no id_valid expected one"); end
  endtask

  task automatic test_stall();
    logic [31:0] exp_addr = 0;
    int acc = 0, pops = 0;
    exp_t e;
    lat = 1;
    do_reset();
    id_ready = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        tests++; if (imem_req_addr !== exp_addr) begin fails++; $display("FAIL stall_addr: got %h expected %h", imem_req_addr, exp_addr); end
        e.pc = exp_addr; e.ins = ins_of(exp_addr); sb.push_back(e);
        acc++; exp_addr += 4;
      end
      if (id_valid) begin
        tests++; if (id_pc !== 32'h0) begin fails++; $display("FAIL stall_hold: got %h expected 0", id_pc); end
      end
      step();
    end
    @(negedge clk);
    tests++; if (acc != 4) begin fails++; $display("FAIL stall_accepts: got %0d expected 4", acc); end
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL stall_req_valid: got %b expected 0", imem_req_valid); end
    tests++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin fails++; $display("FAIL stall_head: got %b/%h expected 1/0", id_valid, id_pc); end
    step();
    id_ready = 1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        tests++; if (imem_req_addr !== exp_addr) begin fails++; $display("FAIL stall_resume_addr: got %h expected %h", imem_req_addr, exp_addr); end
        e.pc = exp_addr; e.ins = ins_of(exp_addr); sb.push_back(e);
        exp_addr += 4;
      end
      if (id_valid && id_ready) begin
        if (sb.size() == 0) begin tests++; fails++; $display("FAIL stall_unexpected: got pc %h expected none", id_pc); end
        else begin
          e = sb.pop_front(); pops++;
          tests++; if (id_pc !== e.pc || id_instr !== e.ins) begin fails++; $display("FAIL stall_drain: got %h/%h expected %h/%h", id_pc, id_instr, e.pc, e.ins); end
        end
      end
      step();
    end
    tests++; if (pops < 8) begin fails++; $display("FAIL stall_pops: got %0d expected >=8", pops); end
  endtask

  task automatic test_redirect();
    logic [31:0] exp_addr = 0;
    int acc = 0;
    logic got_first = 0;
    exp_t e;
    lat = 3;
    do_reset();
    for (int i = 0; i < 20 && acc < 2; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin acc++; exp_addr += 4; end
      if (acc < 2) step();
    end
    tests++; if (acc != 2) begin fails++; $display("FAIL redir_setup: got %0d accepts expected 2", acc); end
    step();
    redirect_valid = 1;
    redirect_pc = 32'h103;
    @(negedge clk);
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL redir_req_valid: got %b expected 0", imem_req_valid); end
    tests++; if (id_valid !== 1'b0) begin fails++; $display("FAIL redir_id_valid: got %b expected 0", id_valid); end
    sb.delete();
    step();
    redirect_valid = 0;
    exp_addr = 32'h100;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) begin
        tests++; if (imem_req_addr !== 32'h100) begin fails++; $display("FAIL redir_addr: got %h expected 00000100", imem_req_addr); end
      end
      if (imem_req_valid && imem_req_ready) begin
        tests++; if (imem_req_addr !== exp_addr) begin fails++; $display("FAIL redir_seq: got %h expected %h", imem_req_addr, exp_addr); end
        e.pc = exp_addr; e.ins = ins_of(exp_addr); sb.push_back(e);
        exp_addr += 4;
      end
      if (id_valid && id_ready) begin
        if (!got_first) begin
          got_first = 1;
          tests++; if (id_pc !== 32'h100) begin fails++; $display("FAIL redir_first_pc: got %h expected 00000100", id_pc); end
        end
        if (sb.size() == 0) begin tests++; fails++; $display("FAIL redir_unexpected: got pc %h expected none", id_pc); end
        else begin
          e = sb.pop_front();
          tests++; if (id_pc !== e.pc || id_instr !== e.ins) begin fails++; $display("FAIL redir_id: got %h/%h expected %h/%h", id_pc, id_instr, e.pc, e.ins); end
        end
      end
      step();
    end
    tests++; if (!got_first) begin fails++; $display("FAIL redir_timeout: got no id_valid expected one"); end
  endtask

  task automatic test_redir_same();
    logic [31:0] exp_addr = 0;
    int pops = 0;
    exp_t e;
    lat = 1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin e.pc = exp_addr; e.ins = ins_of(exp_addr); sb.push_back(e); exp_addr += 4; end
      if (id_valid && id_ready && sb.size() > 0) void'(sb.pop_front());
      step();
    end
    redirect_valid = 1;
    redirect_pc = 32'h200;
    @(negedge clk);
    tests++; if (imem_rsp_valid !== 1'b1) begin fails++; $display("FAIL same_rsp_present: got %b expected 1", imem_rsp_valid); end
    tests++; if (id_valid !== 1'b0) begin fails++; $display("FAIL same_id_valid: got %b expected 0", id_valid); end
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL same_req_valid: got %b expected 0", imem_req_valid); end
    sb.delete();
    step();
    redirect_valid = 0;
    exp_addr = 32'h200;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin
        tests++; if (id_valid !== 1'b0) begin fails++; $display("FAIL same_queue_empty: got %b expected 0", id_valid); end
      end
      if (imem_req_valid && imem_req_ready) begin
        tests++; if (imem_req_addr !== exp_addr) begin fails++; $display("FAIL same_addr: got %h expected %h", imem_req_addr, exp_addr); end
        e.pc = exp_addr; e.ins = ins_of(exp_addr); sb.push_back(e);
        exp_addr += 4;
      end
      if (id_valid && id_ready) begin
        if (sb.size() == 0) begin tests++; fails++; $display("FAIL same_unexpected: got pc %h expected none", id_pc); end
        else begin
          e = sb.pop_front(); pops++;
          tests++; if (id_pc !== e.pc || id_instr !== e.ins) begin fails++; $display("FAIL same_id: got %h/%h expected %h/%h", id_pc, id_instr, e.pc, e.ins); end
        end
      end
      step();
    end
    tests++; if (pops < 3) begin fails++; $display("FAIL same_pops: got %0d expected >=3", pops); end
  endtask

  task automatic test_random();
    logic [31:0] exp_addr = 0;
    int pops = 0;
    exp_t e;
    lat = 2;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        tests++; if (imem_req_addr !== exp_addr) begin fails++; $display("FAIL rand_addr: got %h expected %h", imem_req_addr, exp_addr); end
        e.pc = exp_addr; e.ins = ins_of(exp_addr); sb.push_back(e);
        exp_addr += 4;
      end
      if (id_valid && id_ready) begin
        if (sb.size() == 0) begin tests++; fails++; $display("FAIL rand_unexpected: got pc %h expected none", id_pc); end
        else begin
          e = sb.pop_front(); pops++;
          tests++; if (id_pc !== e.pc || id_instr !== e.ins) begin fails++; $display("FAIL rand_id: got %h/%h expected %h/%h", id_pc, id_instr, e.pc, e.ins); end
        end
      end
      tests++; if (sb.size() > FQ) begin fails++; $display("FAIL rand_overflow: got %0d in flight expected <=%0d", sb.size(), FQ); end
      step();
      imem_req_ready = 1'($urandom % 2);
      id_ready = 1'($urandom % 2);
    end
    tests++; if (pops < 20) begin fails++; $display("FAIL rand_progress: got %0d pops expected >=20", pops); end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    int acc = 0, hs = 0, flushed = 0;
    logic redirected = 0, do_redir = 0;
    exp_t e;
    lat = 3;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin e.pc = imem_req_addr; e.ins = '0; sb.push_back(e); acc++; end
      if (id_valid && id_ready) begin hs++; if (sb.size() > 0) void'(sb.pop_front()); end
      #1;
      if (acc >= 20) break;
      if (!redirected && acc >= 6 && memq.size() == 2 && memq[0].due > cyc + 1) begin
        do_redir = 1;
        flushed = sb.size() - 2;
      end
      step();
      if (do_redir) begin
        redirect_valid = 1;
        redirect_pc = 32'h300;
        @(negedge clk);
        sb.delete();
        step();
        redirect_valid = 0;
        do_redir = 0;
        redirected = 1;
      end
    end
    step();
    imem_req_ready = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (id_valid && id_ready) hs++;
      step();
    end
    @(negedge clk);
    tests++; if (!redirected) begin fails++; $display("FAIL perf_redirect: got no redirect expected one"); end
    tests++; if (perf_squashed !== 32'd2) begin fails++; $display("FAIL perf_squashed: got %0d expected 2", perf_squashed); end
    tests++; if (perf_fetched !== 32'(hs + flushed)) begin fails++; $display("FAIL perf_fetched: got %0d expected %0d", perf_fetched, hs + flushed); end
    tests++; if (perf_stall !== 32'd0) begin fails++; $display("FAIL perf_stall: got %0d expected 0", perf_stall); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_redir_same();
    test_random();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
